// File: rtl/dmem_responder.sv
// dmem_responder: data-memory bus responder with configurable latency and byte-masked writes
// Ports: clk/reset (async, active-high); dmem_req/addr/we/wd/mask request side;
//        dmem_rd read data, dmem_wait stall; proto_err sticky protocol flag;
//        rd_count/wr_count completed reads/writes since reset.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_req,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_we,
    input  logic [31:0] dmem_wd,
    input  logic [3:0]  dmem_mask,
    output logic [31:0] dmem_rd,
    output logic        dmem_wait,
    output logic        proto_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_l;
    logic [31:0] wd_l;
    logic        we_l;
    logic [3:0]  mask_l;
    logic [31:0] mem [DEPTH];
    logic        done;
    logic        op_we;
    logic [31:0] op_wd;
    logic [3:0]  op_mask;
    logic [AW-1:0] idx;
    logic        changed;
    // With zero latency the live request is the operation; otherwise the latched copy is.
    always_comb begin
        done      = !reset && dmem_req && (LATENCY == 0 || state == DONE);
        op_we     = LATENCY == 0 ? dmem_we : we_l;
        op_wd     = LATENCY == 0 ? dmem_wd : wd_l;
        op_mask   = LATENCY == 0 ? dmem_mask : mask_l;
        idx       = LATENCY == 0 ? dmem_addr[AW+1:2] : addr_l[AW+1:2];
        changed   = dmem_addr != addr_l || dmem_we != we_l || dmem_wd != wd_l || dmem_mask != mask_l;
        dmem_rd   = done && !op_we ? mem[idx] : 32'd0;
        dmem_wait = reset ? 1'b1 : LATENCY == 0 ? 1'b0 : state == IDLE ? dmem_req : state == WAIT;
    end
    // Array has no reset so contents survive a reset; done is already gated by reset.
    always_ff @(posedge clk) begin
        if (done && op_we)
            for (int b = 0; b < 4; b++)
                if (op_mask[b]) mem[idx][8*b +: 8] <= op_wd[8*b +: 8];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            proto_err <= 1'b0;
            rd_count  <= 32'd0;
            wr_count  <= 32'd0;
            addr_l    <= 32'd0;
            wd_l      <= 32'd0;
            we_l      <= 1'b0;
            mask_l    <= 4'd0;
        end else begin
            if (done && op_we) wr_count <= wr_count + 32'd1;
            if (done && !op_we) rd_count <= rd_count + 32'd1;
            case (state)
                IDLE: if (dmem_req && LATENCY > 0) begin
                    addr_l <= dmem_addr;
                    wd_l   <= dmem_wd;
                    we_l   <= dmem_we;
                    mask_l <= dmem_mask;
                    cnt    <= 4'(LATENCY - 1);
                    state  <= LATENCY == 1 ? DONE : WAIT;
                end
                WAIT: if (!dmem_req) state <= IDLE;
                else begin
                    if (changed) proto_err <= 1'b1;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized checks of dmem_responder at latencies 2, 3 and 0 against a word-array model
module tb_dmem_responder;
    localparam int LATS [3] = '{2, 3, 0};
    logic clk = 0;
    logic rst = 0;
    logic [2:0] req, we, wt, pe_o;
    logic [2:0][31:0] addr, wd, rd, rc_o, wc_o;
    logic [2:0][3:0] mask;
    logic [31:0] mm [3][1024];
    int unsigned rc [3];
    int unsigned wc [3];
    bit pe [3];
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.DEPTH(1024), .LATENCY(LATS[g])) u (
            .clk(clk), .reset(rst), .dmem_req(req[g]), .dmem_addr(addr[g]), .dmem_we(we[g]),
            .dmem_wd(wd[g]), .dmem_mask(mask[g]), .dmem_rd(rd[g]), .dmem_wait(wt[g]),
            .proto_err(pe_o[g]), .rd_count(rc_o[g]), .wr_count(wc_o[g]));
    end
    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", t, got, exp);
        end
    endtask
    task automatic look(input int k, input string t, input bit cw, input logic ew, input logic [31:0] er);
        if (cw) check($sformatf("%s.wait[%0d]", t, k), {31'd0, wt[k]}, {31'd0, ew});
        check($sformatf("%s.rd[%0d]", t, k), rd[k], er);
        check($sformatf("%s.rd_count[%0d]", t, k), rc_o[k], rc[k]);
        check($sformatf("%s.wr_count[%0d]", t, k), wc_o[k], wc[k]);
        check($sformatf("%s.proto_err[%0d]", t, k), {31'd0, pe_o[k]}, {31'd0, pe[k]});
    endtask
    task automatic drive(input int k, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        req[k] = 1'b1;
        we[k] = w;
        addr[k] = a;
        wd[k] = d;
        mask[k] = m;
    endtask
    task automatic idle(input int k);
        @(negedge clk);
        req[k] = 1'b0;
        #1;
        look(k, "idle", 1, 1'b0, 32'd0);
    endtask
    task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input bit pert, output logic [31:0] got);
        int L;
        int idx;
        logic [31:0] old;
        L = LATS[k];
        idx = int'(a[11:2]);
        old = mm[k][idx];
        got = 32'd0;
        for (int c = 0; c <= L; c++) begin
            @(negedge clk);
            drive(k, w, (pert && c >= 1) ? a ^ 32'h000000C0 : a, d, m);
            #1;
            look(k, "acc", 1, c < L, (c == L && !w) ? old : 32'd0);
            if (pert && c >= 1 && c < L) pe[k] = 1'b1;
            if (c == L) got = rd[k];
        end
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) mm[k][idx][8*b +: 8] = d[8*b +: 8];
            wc[k]++;
        end else rc[k]++;
    endtask
    task automatic start(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            drive(k, w, a, d, m);
            #1;
            look(k, "stall", 1, 1'b1, 32'd0);
        end
    endtask
    task automatic abort(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input int n);
        start(k, w, a, d, m, n);
        @(negedge clk);
        req[k] = 1'b0;
        #1;
        look(k, "drop", 0, 1'b0, 32'd0);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(2, 1'b0, 32'h00001000, 32'd0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            rc[k] = 0;
            wc[k] = 0;
            pe[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 3; k++) look(k, "rst", 1, 1'b1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 3'b000;
        #1;
        for (int k = 0; k < 3; k++) look(k, "post_rst", 1, 1'b0, 32'd0);
    endtask
    task automatic random_ops(input int k, input int n);
        logic [31:0] u, a, d, got;
        int r;
        for (int i = 0; i < n; i++) begin
            u = $urandom();
            d = $urandom();
            a = (u & 32'hFFFFF003) | (32'($urandom_range(0, 31)) << 2);
            r = $urandom_range(0, 9);
            if (r == 0) idle(k);
            else if (r == 1 && LATS[k] > 0) abort(k, u[8], a, d, u[7:4], $urandom_range(1, LATS[k]));
            else access(k, u[8], a, d, u[7:4], LATS[k] > 1 && r == 2, got);
        end
        idle(k);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [31:0] got;
        req = 3'b000;
        we = 3'b000;
        addr = '0;
        wd = '0;
        mask = '0;
        for (int k = 0; k < 3; k++) begin
            rc[k] = 0;
            wc[k] = 0;
            pe[k] = 1'b0;
        end
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) look(k, "reset", 1, 1'b1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 32; w++) access(k, 1'b1, 32'(w) << 2, $urandom(), 4'hF, 1'b0, got);
            idle(k);
        end
        access(0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, got);
        idle(0);
        access(0, 1'b0, 32'h40, 32'd0, 4'd0, 1'b0, got);
        check("t1_read", got, 32'hDEADBEEF);
        access(0, 1'b1, 32'h44, 32'hAABBCCDD, 4'hF, 1'b0, got);
        access(0, 1'b1, 32'h44, 32'h11223344, 4'b0101, 1'b0, got);
        access(0, 1'b0, 32'h44, 32'd0, 4'd0, 1'b0, got);
        check("t2_mask", got, 32'hAA22CC44);
        for (int i = 0; i < 4; i++) access(0, 1'b0, 32'h40 + 32'(4 * i), 32'd0, 4'd0, 1'b0, got);
        idle(0);
        access(0, 1'b0, 32'h40, 32'd0, 4'd0, 1'b1, got);
        check("t5_latched", got, 32'hDEADBEEF);
        idle(0);
        idle(0);
        access(1, 1'b1, 32'h44, 32'h12345678, 4'hF, 1'b0, got);
        idle(1);
        abort(1, 1'b1, 32'h44, 32'h55555555, 4'hF, 1);
        idle(1);
        access(1, 1'b0, 32'h44, 32'd0, 4'd0, 1'b0, got);
        check("t4_unchanged", got, 32'h12345678);
        idle(1);
        access(2, 1'b1, 32'h0, 32'h600DCAFE, 4'hF, 1'b0, got);
        access(2, 1'b0, 32'h1000, 32'd0, 4'd0, 1'b0, got);
        check("t6_alias", got, 32'h600DCAFE);
        idle(2);
        for (int k = 0; k < 3; k++) random_ops(k, 150);
        start(1, 1'b1, 32'h48, 32'h0BADF00D, 4'hF, 2);
        do_reset();
        access(1, 1'b0, 32'h48, 32'd0, 4'd0, 1'b0, got);
        idle(1);
        access(2, 1'b0, 32'h1000, 32'd0, 4'd0, 1'b0, got);
        idle(2);
        access(0, 1'b0, 32'h40, 32'd0, 4'd0, 1'b0, got);
        idle(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
